// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU sequential divider:
//                divider state encoding, iteration count, divide-by-zero
//                quotient and a magnitude helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Divider control states, 2-bit encoding
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // One quotient bit per iteration across the full adder width
    localparam int DIV_ITERS = 32;

    // Quotient reported when the divisor is zero
    localparam logic [31:0] DIV_DBZ_QUOT = 32'hFFFF_FFFF;

    // Unsigned magnitude of a possibly-signed operand; 0x8000_0000 maps to itself
    function automatic logic [31:0] div_mag(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/add_32.sv
`default_nettype none
// ============================================================================
//  Module      : add_32
//  Description : 32-bit adder/subtractor. With sub_in=1 it computes a-b as
//                a + ~b + 1; carry=1 then means no borrow (a >= b unsigned).
//  Revision    : 1.0  initial release
// ============================================================================
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub_in,
    output logic [31:0] res,
    output logic        carry,
    output logic        overflow
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    // Invert b for subtraction and add the sub_in as the carry-in
    always_comb begin
        b_eff    = b ^ {32{sub_in}};
        sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub_in};
        res      = sum[31:0];
        carry    = sum[32];
        overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    end

endmodule : add_32
`default_nettype wire

// File: rtl/div_seq_32.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_32
//  Description : Multi-cycle 32-bit signed/unsigned restoring divider.
//                One quotient bit per cycle using add_32 as trial subtractor.
//                Valid/ready handshake on both operand and result sides.
//  Revision    : 1.0  initial release
// ============================================================================
module div_seq_32
    import alu_pkg::*;
#(
    parameter logic [31:0] DBZ_QUOT = DIV_DBZ_QUOT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_by_zero
);

    // Iteration count is tied to the adder width and is not a parameter
    localparam int ITERS = DIV_ITERS;
    localparam logic [4:0] CNT_START = 5'(ITERS - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d;          // partial remainder, final remainder in DONE
    logic [31:0] q_q, q_d;          // dividend/quotient shift reg, final quotient in DONE
    logic [31:0] d_q, d_d;          // divisor magnitude
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dbz_q, dbz_d;

    logic [31:0] trial;
    logic [31:0] add_res;
    logic        add_carry;
    logic        add_ovf_unused;
    logic        take;
    logic [31:0] iter_r;
    logic [31:0] iter_q;

    // Trial subtraction of the divisor from the shifted partial remainder
    add_32 u_trial_sub (
        .a        (trial),
        .b        (d_q),
        .sub_in   (1'b1),
        .res      (add_res),
        .carry    (add_carry),
        .overflow (add_ovf_unused)
    );

    // One restoring step; the shifted-out msb covers trial values >= 2^32
    always_comb begin
        trial  = {r_q[30:0], q_q[31]};
        take   = r_q[31] | add_carry;
        iter_r = take ? add_res : trial;
        iter_q = {q_q[30:0], take};
    end

    // Next-state and datapath update; sign fix-up applied once on entering DONE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        d_d        = d_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;

        case (state_q)
            DIV_IDLE: begin
                if (in_valid) begin
                    if (b == 32'd0) begin
                        q_d     = DBZ_QUOT;
                        r_d     = a;
                        dbz_d   = 1'b1;
                        state_d = DIV_DONE;
                    end else begin
                        r_d        = 32'd0;
                        q_d        = div_mag(a, sgn);
                        d_d        = div_mag(b, sgn);
                        neg_quot_d = sgn & (a[31] ^ b[31]);
                        neg_rem_d  = sgn & a[31];
                        dbz_d      = 1'b0;
                        cnt_d      = CNT_START;
                        state_d    = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                r_d   = iter_r;
                q_d   = iter_q;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    q_d     = neg_quot_q ? (~iter_q + 32'd1) : iter_q;
                    r_d     = neg_rem_q  ? (~iter_r + 32'd1) : iter_r;
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= 5'd0;
            r_q        <= 32'd0;
            q_q        <= 32'd0;
            d_q        <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            d_q        <= d_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
        end
    end

    // Handshake flags and result outputs straight from state and registers
    always_comb begin
        in_ready    = (state_q == DIV_IDLE);
        out_valid   = (state_q == DIV_DONE);
        quot        = q_q;
        rem         = r_q;
        div_by_zero = dbz_q;
    end

endmodule : div_seq_32
`default_nettype wire

// File: tb/tb_div_seq_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq_32
//  Description : Self-checking bench for div_seq_32: directed cases,
//                backpressure, mid-operation reset and randomized traffic
//                against an arithmetic reference model via a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_seq_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    div_seq_32 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .sgn         (sgn),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] quot;
        logic [31:0] rem;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          acc_cyc = 0;
    bit          seen = 1'b0;
    bit          expect_idle = 1'b0;
    logic [31:0] hq;
    logic [31:0] hr;
    logic        hd;
    int          or_mode = 0;   // 0: always ready, 1: random stalls, 2: hold low

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endfunction

    // Reference: plain arithmetic on wide integers, truncating toward zero
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t   r;
        longint sx;
        longint sy;
        longint qq;
        longint rr;
        if (y == 32'd0) begin
            r.quot = 32'hFFFF_FFFF;
            r.rem  = x;
            r.dbz  = 1'b1;
            r.lat  = 1;
        end else begin
            if (s) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'd0, x});
                sy = longint'({32'd0, y});
            end
            qq     = sx / sy;
            rr     = sx % sy;
            r.quot = qq[31:0];
            r.rem  = rr[31:0];
            r.dbz  = 1'b0;
            r.lat  = 33;
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom % 8)
            0:       return 32'd0;
            1:       return 32'($urandom % 16);
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Consumer-side ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (($urandom % 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency, hold-while-stalled and scoreboard comparison
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            seen        = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                check("idle_in_ready", 64'(in_ready), 64'd1);
                check("idle_out_valid", 64'(out_valid), 64'd0);
                expect_idle = 1'b0;
            end
            if (in_valid && in_ready) acc_cyc = ncyc;
            if (out_valid) begin
                check("busy_in_ready", 64'(in_ready), 64'd0);
                if (!seen) begin
                    seen = 1'b1;
                    hq   = quot;
                    hr   = rem;
                    hd   = div_by_zero;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=quot_%0h required=none", quot);
                    end else begin
                        check("latency", 64'(ncyc - acc_cyc), 64'(sb_q[0].lat));
                    end
                end else begin
                    check("hold_quot", 64'(quot), 64'(hq));
                    check("hold_rem", 64'(rem), 64'(hr));
                    check("hold_dbz", 64'(div_by_zero), 64'(hd));
                end
                if (out_ready) begin
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("quot", 64'(quot), 64'(e.quot));
                        check("rem", 64'(rem), 64'(e.rem));
                        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    end
                    seen        = 1'b0;
                    expect_idle = 1'b1;
                end
            end
        end
    end

    // Issue one request; caller is positioned just after a rising edge
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is, input bit push);
        int n = 0;
        while (!in_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                timeout_fail("issue_wait_in_ready");
                return;
            end
        end
        a        = ia;
        b        = ib;
        sgn      = is;
        in_valid = 1'b1;
        if (push) sb_q.push_back(model(ia, ib, is));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'($urandom);
        b        = 32'($urandom);
        sgn      = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 5000) begin
                timeout_fail("drain");
                sb_q.delete();
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        sgn      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quot", 64'(quot), 64'd0);
        check("rst_rem", 64'(rem), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        issue(32'd100, 32'd7, 1'b0, 1'b1);
        issue(32'h1234, 32'd0, 1'b0, 1'b1);
        issue(32'h1234, 32'd0, 1'b1, 1'b1);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        issue(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1);
        issue(32'd5, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        // Backpressure: result held for 10 cycles
        or_mode = 2;
        issue(32'd1000, 32'd3, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) timeout_fail("wait_out_valid");
        repeat (10) @(posedge clk);
        #1;
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        or_mode = 0;
        drain();

        // Mid-operation reset at cnt=15: aborted request is not scoreboarded
        issue(32'hDEAD_BEEF, 32'd17, 1'b0, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        check("calc_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(32'd9, 32'd3, 1'b0, 1'b1);
        drain();

        // Randomized traffic with random consumer stalls
        or_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            issue(rnd_op(), rnd_op(), 1'($urandom), 1'b1);
        end
        drain();
        or_mode = 0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_seq_32
`default_nettype wire
